pito_hart_watchdog: RTL

- Parametrised multi-hart watchdog and run-length limiter for the pito barrel core.
- Replaces the single fixed simulation-timeout thread with a synthesizable block.
- Tracks a per-hart stall counter, reset by that hart's retire "kick", and a global cycle counter with a programmable limit.
- Sits beside rv32_core: kicks come from the retire stage; outputs feed the CSR/IRQ logic and the testbench done/finish check.

---
 rtl/pito_hart_watchdog.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pito_hart_watchdog.sv
// Multi-hart stall watchdog and global run-length limiter for the pito barrel core.
// Define PITO_WDT_STATS_EN to add the per-hart max_stall statistics output.
module pito_hart_watchdog #(
    parameter int unsigned NUM_HARTS = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned GCNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clr,
    input  logic [NUM_HARTS-1:0]       hart_en,
    input  logic [NUM_HARTS-1:0]       hart_kick,
    input  logic [CNT_W-1:0]           timeout_cfg,
    input  logic [GCNT_W-1:0]          global_limit,
    output logic [NUM_HARTS-1:0]       hart_timeout,
    output logic                       timeout_irq,
    output logic [GCNT_W-1:0]          cycle_count,
    output logic                       sim_done,
`ifdef PITO_WDT_STATS_EN
    output logic [NUM_HARTS*CNT_W-1:0] max_stall,
`endif
    output logic [1:0]                 state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [GCNT_W-1:0]    gcnt_q, gcnt_d, gcnt_inc;
    logic [CNT_W-1:0]     stall_q [NUM_HARTS];
    logic [CNT_W-1:0]     stall_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] tout_q, tout_d, tout_new;
    logic                 irq_q, irq_d;
    logic                 done_q, done_d;

    logic                 restart;
    logic                 advance;
    logic                 cfg_on;
    logic [CNT_W-1:0]     cfg_m1;

    // stop beats start; an accepted start restarts from any state
    assign restart  = start & ~stop;
    assign advance  = (state_q == ST_RUN) & ~stop & ~restart;
    assign cfg_on   = (timeout_cfg != '0);
    assign cfg_m1   = timeout_cfg - CNT_W'(1);
    assign gcnt_inc = (&gcnt_q) ? gcnt_q : gcnt_q + GCNT_W'(1);

    // Run-state sequencing and global cycle counter
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        if (restart) begin
            state_d = ST_RUN;
            gcnt_d  = '0;
        end else if (state_q == ST_RUN) begin
            if (stop) begin
                state_d = ST_IDLE;
            end else begin
                gcnt_d = gcnt_inc;
                if ((global_limit != '0) && (gcnt_inc == global_limit)) begin
                    state_d = ST_EXPIRED;
                end
            end
        end
        done_d = (state_d == ST_EXPIRED);
    end

    // Per-hart stall counters; a timeout fires on the cfg-th kick-free cycle
    always_comb begin
        for (int unsigned i = 0; i < NUM_HARTS; i++) begin
            stall_d[i]  = stall_q[i];
            tout_new[i] = 1'b0;
            if (restart || !hart_en[i]) begin
                stall_d[i] = '0;
            end else if (advance && cfg_on) begin
                if (hart_kick[i]) begin
                    stall_d[i] = '0;
                end else begin
                    stall_d[i]  = (&stall_q[i]) ? stall_q[i] : stall_q[i] + CNT_W'(1);
                    tout_new[i] = (stall_q[i] == cfg_m1);
                end
            end
        end
    end

    // Sticky flags: a fresh timeout outranks clr; only 0->1 edges raise the irq
    always_comb begin
        if (restart) begin
            tout_d = '0;
        end else begin
            tout_d = (clr ? '0 : tout_q) | tout_new;
        end
        irq_d = |(tout_new & ~tout_q);
    end

`ifdef PITO_WDT_STATS_EN
    logic [CNT_W-1:0] max_q [NUM_HARTS];
    logic [CNT_W-1:0] max_d [NUM_HARTS];

    // High-water mark of each stall counter since the last start
    always_comb begin
        for (int unsigned i = 0; i < NUM_HARTS; i++) begin
            max_d[i] = max_q[i];
            if (restart) begin
                max_d[i] = '0;
            end else if (stall_d[i] > max_q[i]) begin
                max_d[i] = stall_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_max_pack
        assign max_stall[g*CNT_W +: CNT_W] = max_q[g];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gcnt_q  <= '0;
            tout_q  <= '0;
            irq_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_HARTS; i++) begin
                stall_q[i] <= '0;
`ifdef PITO_WDT_STATS_EN
                max_q[i]   <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            tout_q  <= tout_d;
            irq_q   <= irq_d;
            done_q  <= done_d;
            for (int unsigned i = 0; i < NUM_HARTS; i++) begin
                stall_q[i] <= stall_d[i];
`ifdef PITO_WDT_STATS_EN
                max_q[i]   <= max_d[i];
`endif
            end
        end
    end

    assign state        = state_q;
    assign cycle_count  = gcnt_q;
    assign hart_timeout = tout_q;
    assign timeout_irq  = irq_q;
    assign sim_done     = done_q;

endmodule
